sha256_host_v2: RTL

SHA256_HOST_V2 -- requirements
Module: sha256_host_v2

---
 rtl/sha256_host_v2.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/sha256_host_v2.sv
// Host-side sequencer for a block-oriented SHA-256 core.
// Streams message words to the core in 16-word blocks and zero-fills the last block.
// Handshakes with the core between blocks, then collects the 8-word digest via the core's readout index.
module sha256_host_v2 (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [11:0]  i_msg_words,
    input  logic         i_s_valid,
    input  logic [31:0]  i_s_data,
    output logic         o_s_ready,
    output logic         o_write,
    output logic [31:0]  o_data,
    output logic [7:0]   o_N,
    output logic [8:0]   o_bit_miss,
    input  logic         i_done,
    input  logic [3:0]   i_read,
    input  logic [31:0]  i_hash_data,
    output logic [255:0] o_digest,
    output logic         o_digest_valid,
    output logic         o_busy,
    output logic         o_err
);

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned LEN_W     = 12;
    localparam int unsigned BW_W      = 5;
    localparam int unsigned BLK_WORDS = 16;
    localparam int unsigned MAX_WORDS = 4080;
    localparam int unsigned DIG_WORDS = 8;
    localparam int unsigned DIG_W     = WORD_W * DIG_WORDS;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FILL,
        WAIT_BUSY,
        WAIT_DONE,
        COLLECT,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   words_q, words_d;
    logic [BW_W-1:0]    bw_q, bw_d;
    logic [7:0]         blk_q, blk_d;
    logic [7:0]         n_q, n_d;
    logic [8:0]         miss_q, miss_d;
    logic [3:0]         rd_q, rd_d;
    logic               ready_q, ready_d;
    logic               write_q, write_d;
    logic [WORD_W-1:0]  data_q, data_d;
    logic [DIG_W-1:0]   digest_q, digest_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    logic               accept;
    logic               last_word;
    logic               blk_full;
    logic               len_ok;
    logic [LEN_W-1:0]   len_m1;

    // Request decode and stream handshake terms
    always_comb begin
        len_ok    = (i_msg_words != '0) && (i_msg_words <= LEN_W'(MAX_WORDS));
        len_m1    = i_msg_words - LEN_W'(1);
        accept    = i_s_valid && ready_q;
        last_word = (words_q + LEN_W'(1)) == len_q;
        blk_full  = bw_q == BW_W'(BLK_WORDS - 1);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        words_d  = words_q;
        bw_d     = bw_q;
        blk_d    = blk_q;
        n_d      = n_q;
        miss_d   = miss_q;
        rd_d     = '0;
        write_d  = 1'b0;
        data_d   = data_q;
        digest_d = digest_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (!len_ok) begin
                        err_d = 1'b1;
                    end else begin
                        len_d   = i_msg_words;
                        n_d     = 8'((13'(i_msg_words) + 13'd15) >> 4);
                        miss_d  = {4'(4'd15 - len_m1[3:0]), 5'b0};
                        words_d = '0;
                        bw_d    = '0;
                        blk_d   = '0;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    write_d = 1'b1;
                    data_d  = i_s_data;
                    words_d = words_q + LEN_W'(1);
                    bw_d    = bw_q + BW_W'(1);
                    if (last_word) begin
                        // Final block goes straight to readout once its 16th write is issued
                        state_d = blk_full ? COLLECT : FILL;
                    end else if (blk_full) begin
                        state_d = WAIT_BUSY;
                    end
                end
            end
            FILL: begin
                write_d = 1'b1;
                data_d  = '0;
                bw_d    = bw_q + BW_W'(1);
                if (blk_full) begin
                    state_d = COLLECT;
                end
            end
            WAIT_BUSY: begin
                if (!i_done) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (i_done) begin
                    blk_d   = blk_q + 8'd1;
                    bw_d    = '0;
                    state_d = LOAD;
                end
            end
            COLLECT: begin
                rd_d = i_read;
                for (int unsigned k = 1; k <= DIG_WORDS; k++) begin
                    if (rd_q == 4'(k)) begin
                        digest_d[WORD_W*(DIG_WORDS-k) +: WORD_W] = i_hash_data;
                    end
                end
                if (rd_q == 4'(DIG_WORDS)) begin
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == LOAD);
        busy_d  = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= IDLE;
            len_q    <= '0;
            words_q  <= '0;
            bw_q     <= '0;
            blk_q    <= '0;
            n_q      <= '0;
            miss_q   <= '0;
            rd_q     <= '0;
            ready_q  <= 1'b0;
            write_q  <= 1'b0;
            data_q   <= '0;
            digest_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            words_q  <= words_d;
            bw_q     <= bw_d;
            blk_q    <= blk_d;
            n_q      <= n_d;
            miss_q   <= miss_d;
            rd_q     <= rd_d;
            ready_q  <= ready_d;
            write_q  <= write_d;
            data_q   <= data_d;
            digest_q <= digest_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign o_s_ready      = ready_q;
    assign o_write        = write_q;
    assign o_data         = data_q;
    assign o_N            = n_q;
    assign o_bit_miss     = miss_q;
    assign o_digest       = digest_q;
    assign o_digest_valid = valid_q;
    assign o_busy         = busy_q;
    assign o_err          = err_q;

endmodule
